// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter checks for the single-clock flagged FIFO.
package sync_fifo_pkg;

    localparam int DEFAULT_ADDR_SIZE = 4;

    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

    // Pointers and the occupancy counter both carry one extra bit so DEPTH itself is representable.
    function automatic int ptr_width(input int addr_size);
        return addr_size + 1;
    endfunction

    function automatic int count_width(input int addr_size);
        return addr_size + 1;
    endfunction

    localparam int DEFAULT_PTR_W   = DEFAULT_ADDR_SIZE + 1;
    localparam int DEFAULT_COUNT_W = DEFAULT_ADDR_SIZE + 1;

    function automatic bit thresholds_legal(input int addr_size, input int afull, input int aempty);
        return (afull >= 1) && (afull <= fifo_depth(addr_size)) &&
               (aempty >= 0) && (aempty <= fifo_depth(addr_size) - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_flags_mem.sv
// Simple dual-port RAM: one write port, one registered read port, array left unreset.
module fifo_mem_1clk
    import sync_fifo_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wen,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 ren,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_SIZE);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen)
            mem[waddr] <= wdata;
    end

    // Only the output register is reset; it holds its value whenever no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (ren)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, flush and sticky error flags.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DATA_SIZE     = 8,
    parameter int ADDR_SIZE     = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 winc,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 rinc,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 rvalid,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic                 rempty,
    output logic                 ralmost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int PTR_W = ptr_width(ADDR_SIZE);
    localparam int CNT_W = count_width(ADDR_SIZE);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

    if (!thresholds_legal(ADDR_SIZE, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
        $error("sync_fifo_flags: AFULL_THRESH must be 1..DEPTH and AEMPTY_THRESH 0..DEPTH-1");
    end

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             wr_accept;
    logic             rd_accept;

    assign rempty        = (wptr == rptr);
    assign wfull         = (wptr[ADDR_SIZE] != rptr[ADDR_SIZE]) &&
                           (wptr[ADDR_SIZE-1:0] == rptr[ADDR_SIZE-1:0]);
    assign walmost_full  = (count >= AFULL_C);
    assign ralmost_empty = (count <= AEMPTY_C);

    // A flush swallows both requests, so neither can be accepted nor flagged as an error.
    assign wr_accept = winc && !wfull  && !clear;
    assign rd_accept = rinc && !rempty && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rvalid    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rvalid    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept)
                wptr <= wptr + PTR_W'(1);
            if (rd_accept)
                rptr <= rptr + PTR_W'(1);
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            rvalid <= rd_accept;
            if (winc && wfull)
                overflow <= 1'b1;
            if (rinc && rempty)
                underflow <= 1'b1;
        end
    end

    fifo_mem_1clk #(
        .DATA_SIZE(DATA_SIZE),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_mem (
        .clk  (clk),
        .rst_n(rst_n),
        .wen  (wr_accept),
        .waddr(wptr[ADDR_SIZE-1:0]),
        .wdata(wdata),
        .ren  (rd_accept),
        .raddr(rptr[ADDR_SIZE-1:0]),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: vector table, directed corner sequences and random traffic vs a queue model.
module tb_sync_fifo_flags;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;
    localparam int AEMPTY = 2;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;
    logic [7:0] rdata;
    logic       rvalid;
    logic       wfull;
    logic       walmost_full;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int total;
    int bad;

    // Reference model: a plain queue of words plus the sticky flags and read-port state.
    logic [7:0] model_q[$];
    logic       m_ov;
    logic       m_un;
    logic       m_valid;
    logic [7:0] m_data;

    typedef struct {
        logic       clr;
        logic       w;
        logic       r;
        logic [7:0] wd;
        int         exp_count;
        logic       exp_rvalid;
        logic [7:0] exp_rdata;
        logic       exp_un;
    } vec_t;

    vec_t vecs[8];

    sync_fifo_flags dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .winc         (winc),
        .wdata        (wdata),
        .rinc         (rinc),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .rempty       (rempty),
        .ralmost_empty(ralmost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        m_ov    = 1'b0;
        m_un    = 1'b0;
        m_valid = 1'b0;
        m_data  = 8'h00;
    endtask

    task automatic modelStep(input logic c, input logic w, input logic r, input logic [7:0] d);
        int n;
        n = model_q.size();
        if (c) begin
            model_q.delete();
            m_ov    = 1'b0;
            m_un    = 1'b0;
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (r && n > 0) begin
                m_data  = model_q.pop_front();
                m_valid = 1'b1;
            end
            if (w && n < DEPTH)
                model_q.push_back(d);
            if (w && n == DEPTH)
                m_ov = 1'b1;
            if (r && n == 0)
                m_un = 1'b1;
        end
    endtask

    task automatic checkOutput();
        int n;
        n = model_q.size();
        checkVal("count", 32'(count), 32'(n));
        checkVal("wfull", 32'(wfull), 32'(n == DEPTH));
        checkVal("rempty", 32'(rempty), 32'(n == 0));
        checkVal("walmost_full", 32'(walmost_full), 32'(n >= AFULL));
        checkVal("ralmost_empty", 32'(ralmost_empty), 32'(n <= AEMPTY));
        checkVal("overflow", 32'(overflow), 32'(m_ov));
        checkVal("underflow", 32'(underflow), 32'(m_un));
        checkVal("rvalid", 32'(rvalid), 32'(m_valid));
        checkVal("rdata", 32'(rdata), 32'(m_data));
    endtask

    // Drive one cycle of requests, advance the model across the edge, then check just after it.
    task automatic applyStimulus(input logic c, input logic w, input logic r, input logic [7:0] d);
        clear = c;
        winc  = w;
        rinc  = r;
        wdata = d;
        @(posedge clk);
        modelStep(c, w, r, d);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [7:0] pat;
        total = 0;
        bad   = 0;
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'hA1, 1, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'hB2, 2, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'hC3, 3, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 2, 1'b1, 8'hA1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 8'hD4, 2, 1'b1, 8'hB2, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 8'hB2, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 8'hE5, 0, 1'b0, 8'hB2, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'hB2, 1'b1};

        rst_n = 1'b0;
        clear = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = 8'h00;
        modelReset();
        #12;
        checkOutput();
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].clr, vecs[i].w, vecs[i].r, vecs[i].wd);
            checkVal($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            checkVal($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].exp_rvalid));
            checkVal($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
            checkVal($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].exp_un));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

        $display("[TB] fill to full, then overflow");
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(i));
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h55);
        checkVal("overflow_after_17th", 32'(overflow), 32'd1);
        checkVal("count_after_17th", 32'(count), 32'd16);

        $display("[TB] drain from full, then underflow");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            checkVal("drain_order", 32'(rdata), 32'(i));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkVal("extra_read_rdata_hold", 32'(rdata), 32'h0F);
        checkVal("extra_read_rvalid", 32'(rvalid), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

        $display("[TB] streaming at count=5 across pointer wrap");
        pat = 8'h00;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, pat);
            pat++;
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, pat);
            checkVal("stream_rdata", 32'(rdata), 32'(8'(pat - 8'd5)));
            pat++;
        end
        checkVal("stream_count", 32'(count), 32'd5);

        $display("[TB] simultaneous read/write while full");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, pat);
            pat++;
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hEE);
        checkVal("full_rw_count", 32'(count), 32'd15);
        checkVal("full_rw_overflow", 32'(overflow), 32'd1);

        $display("[TB] simultaneous read/write while empty");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h77);
        checkVal("empty_rw_count", 32'(count), 32'd1);
        checkVal("empty_rw_underflow", 32'(underflow), 32'd1);

        $display("[TB] clear with winc at count=9 and errors set");
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h99);
        checkVal("clear_count", 32'(count), 32'd0);
        checkVal("clear_err", 32'({overflow, underflow}), 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i / 50) % 2 == 0 ? 70 : 30;
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < bias,
                          $urandom_range(0, 99) < (100 - bias),
                          8'($urandom));
        end

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b1, 1'(i % 2), 8'(8'hC0 + i));
        #2;
        rst_n = 1'b0;
        clear = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkVal("post_reset_read", 32'(rdata), 32'h5A);

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
